// File: rtl/bcd_cnt_scan_pkg.sv
// bcd_cnt_scan_pkg: shared BCD digit type, limits and scanner state for bcd_cnt_scan
package bcd_cnt_scan_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  typedef enum logic {IDLE, SEND} scan_state_t;
  function automatic logic is_bcd(bcd_t d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_cnt_scan_if.sv
// bcd_cnt_scan_if: digit stream handshake from the scanner to the BCD-to-Excess-3 stage
interface bcd_cnt_scan_if;
  logic [3:0] bcd_o4;
  logic [2:0] dig_idx_o;
  logic       vld_o;
  logic       rdy_i;
  logic       done_o;
  modport master (output bcd_o4, dig_idx_o, vld_o, done_o, input rdy_i);
  modport slave (input bcd_o4, dig_idx_o, vld_o, done_o, output rdy_i);
endinterface

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one BCD digit +/-1 when ci is set, co flags wrap (9->0 up, 0->9 down)
module bcd_digit_step
  import bcd_cnt_scan_pkg::*;
(
  input  bcd_t d,
  input  logic up,
  input  logic ci,
  output bcd_t q,
  output logic co
);
  logic edge_val;
  assign edge_val = up ? (d == BCD_MAX) : (d == 4'd0);
  assign co = ci & edge_val;
  assign q = !ci ? d : edge_val ? (up ? 4'd0 : BCD_MAX) : up ? d + 4'd1 : d - 4'd1;
endmodule

// File: rtl/bcd_cnt_scan.sv
// bcd_cnt_scan: NUM_DIGITS BCD counter with checked load and MSD-first digit scanner
// Define BCD_CNT_DOWN_EN to add up_i and decimal down-counting.
module bcd_cnt_scan
  import bcd_cnt_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
`ifdef BCD_CNT_DOWN_EN
  input  logic                    up_i,
`endif
  input  logic                    ld_i,
  input  logic [4*NUM_DIGITS-1:0] ld_bcd_i,
  output logic [4*NUM_DIGITS-1:0] cnt_o,
  output logic                    carry_o,
  output logic                    ld_err_o,
  input  logic                    scan_req_i,
  bcd_cnt_scan_if.master          scan
);
  logic                    up;
  logic [NUM_DIGITS:0]     c;
  logic [4*NUM_DIGITS-1:0] cnt_n;
  logic                    ld_ok;
  scan_state_t             state, state_n;
  logic [2:0]              idx, idx_n;
  logic [4*NUM_DIGITS-1:0] snap, snap_n, snap_sh;
`ifdef BCD_CNT_DOWN_EN
  assign up = up_i;
`else
  assign up = 1'b1;
`endif
  assign c[0] = en_i;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_step u_step (
      .d  (cnt_o[4*i+:4]),
      .up (up),
      .ci (c[i]),
      .q  (cnt_n[4*i+:4]),
      .co (c[i+1])
    );
  end
  always_comb begin
    ld_ok = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) ld_ok = ld_ok & is_bcd(ld_bcd_i[4*k+:4]);
  end
  // A load cycle, accepted or not, never steps the count nor raises carry.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_o    <= '0;
      carry_o  <= 1'b0;
      ld_err_o <= 1'b0;
    end else begin
      carry_o  <= !ld_i && c[NUM_DIGITS];
      ld_err_o <= ld_i && !ld_ok;
      cnt_o    <= ld_i ? (ld_ok ? ld_bcd_i : cnt_o) : cnt_n;
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      idx   <= '0;
      snap  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      snap  <= snap_n;
    end
  always_comb begin
    state_n = state;
    idx_n   = idx;
    snap_n  = snap;
    if (state == IDLE) begin
      state_n = scan_req_i ? SEND : IDLE;
      idx_n   = scan_req_i ? 3'(NUM_DIGITS - 1) : idx;
      snap_n  = scan_req_i ? cnt_o : snap;
    end else if (scan.rdy_i) begin
      state_n = (idx == 3'd0) ? IDLE : SEND;
      idx_n   = (idx == 3'd0) ? 3'd0 : idx - 3'd1;
    end
  end
  assign snap_sh        = snap >> {idx, 2'b00};
  assign scan.vld_o     = (state == SEND);
  assign scan.bcd_o4    = scan.vld_o ? snap_sh[3:0] : 4'd0;
  assign scan.dig_idx_o = scan.vld_o ? idx : 3'd0;
  assign scan.done_o    = scan.vld_o && scan.rdy_i && (idx == 3'd0);
endmodule

// File: doc/bcd_cnt_scan.md
BCD_CNT_SCAN -- requirements
Module: bcd_cnt_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of BCD digits held by the counter (legal range 2..8).
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en_i  input  1  count-enable; one step per cycle while high.
REQ-005 SHALL have port up_i  input  1  count direction, 1 = up, 0 = down (present only under the configuration macro).
REQ-006 SHALL have port ld_i  input  1  synchronous load strobe.
REQ-007 SHALL have port ld_bcd_i  input  4*NUM_DIGITS  load value, digit 0 in bits [3:0].
REQ-008 SHALL have port cnt_o  output  4*NUM_DIGITS  current count, packed BCD.
REQ-009 SHALL have port carry_o  output  1  one-cycle pulse on wrap-around.
REQ-010 SHALL have port ld_err_o  output  1  one-cycle pulse on rejected load.
REQ-011 SHALL have port scan_req_i  input  1  request to stream a snapshot of cnt_o.
REQ-012 SHALL have port bcd_o4  output  4  current streamed digit, feeds the BCD-to-Excess-3 stage.
REQ-013 SHALL have port dig_idx_o  output  3  index of the streamed digit.
REQ-014 SHALL have port vld_o  input-side valid, output  1  bcd_o4/dig_idx_o valid.
REQ-015 SHALL have port rdy_i  input  1  downstream ready.
REQ-016 SHALL have port done_o  output  1  one-cycle pulse after last digit accepted.

Function
REQ-017 SHALL keep every digit of cnt_o in 0..9 at all times.
REQ-018 SHALL, when en_i=1 and counting up, add 1 with decimal ripple: digit 9 becomes 0 and carries into the next digit, in the same cycle.
REQ-019 SHALL, counting up from all-9s, wrap to all-0s and pulse carry_o for exactly that cycle.
REQ-020 SHALL give ld_i priority over en_i; a loaded cycle performs no count step and no carry.
REQ-021 SHALL reject a load with any digit > 9: cnt_o unchanged, ld_err_o pulsed for one cycle.
REQ-022 SHALL implement scanner FSM with states IDLE and SEND only.
REQ-023 SHALL, in IDLE with scan_req_i=1, capture cnt_o into a snapshot register and enter SEND next cycle, starting at digit NUM_DIGITS-1 (most significant first).
REQ-024 SHALL in SEND hold vld_o=1 with bcd_o4/dig_idx_o stable until rdy_i=1 (transfer = vld_o & rdy_i).
REQ-025 SHALL on each transfer decrement dig_idx_o; on transfer of digit 0 return to IDLE and pulse done_o the same cycle.
REQ-026 SHALL ignore scan_req_i while in SEND; counting and loads during SEND SHALL NOT alter the snapshot.
REQ-027 SHALL drive vld_o=0, bcd_o4=0, dig_idx_o=0 in IDLE.

Reset
REQ-028 SHALL on rst_ni=0 immediately clear cnt_o, snapshot, carry_o, ld_err_o, vld_o, done_o, bcd_o4, dig_idx_o to 0 and force IDLE, including mid-scan; no done_o follows an aborted scan.

Configuration
REQ-029 SHALL, with BCD_CNT_DOWN_EN defined, provide up_i; down-count subtracts 1 with decimal borrow (0 becomes 9), all-0s wraps to all-9s with carry_o pulse.
REQ-030 SHALL, without BCD_CNT_DOWN_EN, omit up_i and count up only.

Structure
REQ-031 SHALL place in a shared package: BCD digit typedef (4 bits), constant BCD_MAX=9, scanner state enum.
REQ-032 SHALL use one sub-module bcd_digit_step (single digit +/-1 with carry/borrow in/out), instantiated NUM_DIGITS times.

Verification
REQ-033 SHALL cover: load 0x0999, en_i 1 cycle -> cnt_o=0x1000, carry_o=0.
REQ-034 SHALL cover: load 0x9999, en_i 1 cycle -> cnt_o=0x0000, carry_o high exactly 1 cycle.
REQ-035 SHALL cover: ld_bcd_i=0x12A4 -> ld_err_o 1 cycle, cnt_o unchanged.
REQ-036 SHALL cover: cnt=0x4721, scan_req_i, rdy_i toggling 1/0 -> digits 4,7,2,1 with idx 3,2,1,0, held across stalls, done_o once; counting meanwhile does not change streamed values.
REQ-037 SHALL cover: rst_ni low after second digit transfer -> vld_o=0 immediately, no done_o, cnt_o=0.
REQ-038 SHALL cover (BCD_CNT_DOWN_EN): load 0x0000, up_i=0, en_i 1 cycle -> cnt_o=0x9999, carry_o pulse.
